rv_fetch_decode: RTL and testbench

Parametrised instruction fetch-and-decode front end for the RV64 subset core. It streams instruction words from the instruction memory, decodes each into one-hot instruction type, one-hot format, and a sign-extended immediate, and buffers the results in a DEPTH-entry FIFO. The FIFO drains to the execute stage through a valid/ready handshake. A redirect port flushes the buffer and restarts fetch at a new word address on taken branches and jumps.

---
 rtl/rv_fetch_decode.sv | 252 +++++++++++++++++++++++++
 tb/tb_rv_fetch_decode.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/rv_fetch_decode.sv
// rv_fetch_decode: instruction fetch + decode front end for the RV64 subset core.
// Fetches one word per cycle, decodes it into one-hot type/format plus a
// sign-extended immediate, and queues the result in a DEPTH-entry FIFO that
// drains to execute over a valid/ready handshake. A redirect flushes the queue
// and restarts fetch at a new word address.
// Optional build macro: RV_DECODE_STRICT_EN selects full opcode/funct3/funct7
// checking with illegal-instruction reporting; otherwise a compact decode runs.
module rv_fetch_decode #(
    parameter int                ADDR_W   = 32,
    parameter int                DEPTH    = 4,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic                         clk,
    input  logic                         rst_n,
    output logic [ADDR_W-3:0]            mem_addr_I,
    input  logic [31:0]                  mem_rdata_I,
    input  logic                         redirect_valid,
    input  logic [ADDR_W-3:0]            redirect_addr,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [ADDR_W-3:0]            out_pc,
    output logic [22:0]                  out_type,
    output logic [4:0]                   out_format,
    output logic [31:0]                  out_imm,
    output logic                         out_illegal,
    output logic [$clog2(DEPTH+1)-1:0]   count
);

    localparam int WA = ADDR_W - 2;
    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);
    localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);

    // One-hot type bit positions
    localparam int T_JAL  = 22, T_JALR = 21, T_BEQ  = 20, T_BNE  = 19;
    localparam int T_LD   = 18, T_SD   = 17, T_ADDI = 16, T_SLTI = 15;
    localparam int T_XORI = 14, T_ORI  = 13, T_ANDI = 12, T_SLLI = 11;
    localparam int T_SRLI = 10, T_SRAI = 9,  T_ADD  = 8,  T_SUB  = 7;
    localparam int T_SLL  = 6,  T_SLT  = 5,  T_XOR  = 4,  T_SRL  = 3;
    localparam int T_SRA  = 2,  T_OR   = 1,  T_AND  = 0;

    // One-hot format bit positions
    localparam int F_R = 4, F_I = 3, F_S = 2, F_B = 1, F_J = 0;

    typedef struct packed {
        logic [WA-1:0] pc;
        logic [22:0]   itype;
        logic [4:0]    fmt;
        logic [31:0]   imm;
        logic          illegal;
    } entry_t;

    logic [31:0]   inst;
    logic [2:0]    funct3;
    logic [22:0]   dec_type;
    logic [4:0]    dec_fmt;
    logic [31:0]   dec_imm;
    logic          dec_illegal;
    logic          unused_inst_bits;

    logic [WA-1:0] pc;
    logic [PW-1:0] rd_ptr;
    logic [PW-1:0] wr_ptr;
    logic          push;
    logic          pop;
    entry_t        fifo_mem [DEPTH];
    entry_t        head;

    assign inst             = mem_rdata_I;
    assign funct3           = inst[14:12];
    assign unused_inst_bits = ^{inst[6], inst[1:0]};

`ifdef RV_DECODE_STRICT_EN
    logic [6:0] opcode;
    logic [6:0] funct7;
    assign opcode = inst[6:0];
    assign funct7 = inst[31:25];

    // Strict decode: every opcode, funct3 and funct7 field must match exactly
    always_comb begin
        dec_type = '0;
        case (opcode)
            7'b0000011: if (funct3 == 3'b011) dec_type[T_LD] = 1'b1;
            7'b0100011: if (funct3 == 3'b011) dec_type[T_SD] = 1'b1;
            7'b1100011: begin
                if (funct3 == 3'b000) dec_type[T_BEQ] = 1'b1;
                else if (funct3 == 3'b001) dec_type[T_BNE] = 1'b1;
            end
            7'b1100111: if (funct3 == 3'b000) dec_type[T_JALR] = 1'b1;
            7'b1101111: dec_type[T_JAL] = 1'b1;
            7'b0010011: begin
                case (funct3)
                    3'b000: dec_type[T_ADDI] = 1'b1;
                    3'b010: dec_type[T_SLTI] = 1'b1;
                    3'b100: dec_type[T_XORI] = 1'b1;
                    3'b110: dec_type[T_ORI]  = 1'b1;
                    3'b111: dec_type[T_ANDI] = 1'b1;
                    3'b001: if (funct7 == 7'b0000000) dec_type[T_SLLI] = 1'b1;
                    3'b101: begin
                        if (funct7 == 7'b0000000) dec_type[T_SRLI] = 1'b1;
                        else if (funct7 == 7'b0100000) dec_type[T_SRAI] = 1'b1;
                    end
                    default: ;
                endcase
            end
            7'b0110011: begin
                if (funct7 == 7'b0000000) begin
                    case (funct3)
                        3'b000: dec_type[T_ADD] = 1'b1;
                        3'b001: dec_type[T_SLL] = 1'b1;
                        3'b010: dec_type[T_SLT] = 1'b1;
                        3'b100: dec_type[T_XOR] = 1'b1;
                        3'b101: dec_type[T_SRL] = 1'b1;
                        3'b110: dec_type[T_OR]  = 1'b1;
                        3'b111: dec_type[T_AND] = 1'b1;
                        default: ;
                    endcase
                end else if (funct7 == 7'b0100000) begin
                    if (funct3 == 3'b000) dec_type[T_SUB] = 1'b1;
                    else if (funct3 == 3'b101) dec_type[T_SRA] = 1'b1;
                end
            end
            default: ;
        endcase
    end

    assign dec_illegal = ~|dec_type;
`else
    // Compact decode: opcode bits [5:2] pick the class, funct3 and bit 30 pick the op
    always_comb begin
        dec_type = '0;
        case (inst[5:2])
            4'b0000: if (funct3 == 3'b011) dec_type[T_LD] = 1'b1;
            4'b1000: begin
                case (funct3)
                    3'b011: dec_type[T_SD]  = 1'b1;
                    3'b000: dec_type[T_BEQ] = 1'b1;
                    3'b001: dec_type[T_BNE] = 1'b1;
                    default: ;
                endcase
            end
            4'b1001: if (funct3 == 3'b000) dec_type[T_JALR] = 1'b1;
            4'b1011: dec_type[T_JAL] = 1'b1;
            4'b0100: begin
                case (funct3)
                    3'b000: dec_type[T_ADDI] = 1'b1;
                    3'b010: dec_type[T_SLTI] = 1'b1;
                    3'b100: dec_type[T_XORI] = 1'b1;
                    3'b110: dec_type[T_ORI]  = 1'b1;
                    3'b111: dec_type[T_ANDI] = 1'b1;
                    3'b001: dec_type[T_SLLI] = 1'b1;
                    3'b101: dec_type[inst[30] ? T_SRAI : T_SRLI] = 1'b1;
                    default: ;
                endcase
            end
            4'b1100: begin
                case (funct3)
                    3'b000: dec_type[inst[30] ? T_SUB : T_ADD] = 1'b1;
                    3'b001: dec_type[T_SLL] = 1'b1;
                    3'b010: dec_type[T_SLT] = 1'b1;
                    3'b100: dec_type[T_XOR] = 1'b1;
                    3'b101: dec_type[inst[30] ? T_SRA : T_SRL] = 1'b1;
                    3'b110: dec_type[T_OR]  = 1'b1;
                    3'b111: dec_type[T_AND] = 1'b1;
                    default: ;
                endcase
            end
            default: ;
        endcase
    end

    assign dec_illegal = 1'b0;
`endif

    // Format follows directly from the decoded type; unmatched words get no format
    assign dec_fmt[F_R] = |dec_type[T_SUB+1:T_AND];
    assign dec_fmt[F_I] = dec_type[T_JALR] | dec_type[T_LD] | (|dec_type[T_ADDI:T_SRAI]);
    assign dec_fmt[F_S] = dec_type[T_SD];
    assign dec_fmt[F_B] = dec_type[T_BEQ] | dec_type[T_BNE];
    assign dec_fmt[F_J] = dec_type[T_JAL];

    // Immediate assembly by format; R-type and unmatched words carry zero
    always_comb begin
        dec_imm = '0;
        if (dec_fmt[F_I])
            dec_imm = {{20{inst[31]}}, inst[31:20]};
        else if (dec_fmt[F_S])
            dec_imm = {{20{inst[31]}}, inst[31:25], inst[11:7]};
        else if (dec_fmt[F_B])
            dec_imm = {{19{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
        else if (dec_fmt[F_J])
            dec_imm = {{11{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};
    end

    // A redirect suppresses the push; a full queue can still push if the head leaves
    assign pop        = out_valid && out_ready;
    assign push       = !redirect_valid && ((count < FULL_COUNT) || pop);
    assign mem_addr_I = pc;
    assign out_valid  = (count != '0);

    // Fetch pointer and FIFO bookkeeping; redirect empties the queue and reloads fetch
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc     <= RESET_PC[ADDR_W-1:2];
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else if (redirect_valid) begin
            pc     <= redirect_addr;
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                pc     <= pc + WA'(1);
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (pop)
                rd_ptr <= rd_ptr + PW'(1);
            if (push && !pop)
                count <= count + CW'(1);
            else if (pop && !push)
                count <= count - CW'(1);
        end
    end

    // Entry storage needs no reset: empty slots are never shown on the outputs
    always_ff @(posedge clk) begin
        if (push)
            fifo_mem[wr_ptr] <= '{pc: pc, itype: dec_type, fmt: dec_fmt,
                                  imm: dec_imm, illegal: dec_illegal};
    end

    assign head = fifo_mem[rd_ptr];

    // Head payload is forced to zero whenever the queue is empty
    always_comb begin
        out_pc      = '0;
        out_type    = '0;
        out_format  = '0;
        out_imm     = '0;
        out_illegal = 1'b0;
        if (out_valid) begin
            out_pc      = head.pc;
            out_type    = head.itype;
            out_format  = head.fmt;
            out_imm     = head.imm;
            out_illegal = head.illegal;
        end
    end

endmodule

// File: tb/tb_rv_fetch_decode.sv
// tb_rv_fetch_decode: directed bench for rv_fetch_decode with a small
// combinational instruction memory. Honours RV_DECODE_STRICT_EN when defined.
module tb_rv_fetch_decode;

    logic        clk;
    logic        rst_n;
    logic [29:0] mem_addr_I;
    logic [31:0] mem_rdata_I;
    logic        redirect_valid;
    logic [29:0] redirect_addr;
    logic        out_valid;
    logic        out_ready;
    logic [29:0] out_pc;
    logic [22:0] out_type;
    logic [4:0]  out_format;
    logic [31:0] out_imm;
    logic        out_illegal;
    logic [2:0]  fifo_count;

    int checks = 0;
    int errors = 0;

    logic [31:0] imem [0:127];

    rv_fetch_decode #(.ADDR_W(32), .DEPTH(4), .RESET_PC(32'h0)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .mem_addr_I     (mem_addr_I),
        .mem_rdata_I    (mem_rdata_I),
        .redirect_valid (redirect_valid),
        .redirect_addr  (redirect_addr),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_pc         (out_pc),
        .out_type       (out_type),
        .out_format     (out_format),
        .out_imm        (out_imm),
        .out_illegal    (out_illegal),
        .count          (fifo_count)
    );

    assign mem_rdata_I = imem[mem_addr_I[6:0]];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory image: addi x1,x0,k at word k, plus hand-picked words
    task automatic load_memory();
        for (int i = 0; i < 128; i++)
            imem[i] = 32'h0000_0093 | (32'(i) << 20);
        imem[0]     = 32'h0050_0093;
        imem[1]     = 32'h4020_81B3;
        imem[2]     = 32'hFE00_0EE3;
        imem[7'h40] = 32'hFF81_3083;
        imem[7'h41] = 32'h0031_3623;
        imem[7'h42] = 32'hFF9F_F06F;
        imem[7'h43] = 32'h4033_5293;
        imem[7'h44] = 32'h0042_80E7;
        imem[7'h45] = 32'h0000_0000;
        imem[7'h46] = 32'h0020_9863;
        imem[7'h47] = 32'h0020_F1B3;
    endtask

    task automatic test_reset();
        rst_n          = 1'b0;
        out_ready      = 1'b0;
        redirect_valid = 1'b0;
        redirect_addr  = '0;
        repeat (3) @(negedge clk);
        checks++;
        if (mem_addr_I !== 30'd0) begin
            errors++; $display("[TB] FAIL reset_addr: got %0h expected 0", mem_addr_I);
        end
        checks++;
        if (fifo_count !== 3'd0) begin
            errors++; $display("[TB] FAIL reset_count: got %0d expected 0", fifo_count);
        end
        checks++;
        if (out_valid !== 1'b0) begin
            errors++; $display("[TB] FAIL reset_valid: got %0b expected 0", out_valid);
        end
        checks++;
        if ({out_pc, out_type, out_format, out_imm, out_illegal} !== '0) begin
            errors++; $display("[TB] FAIL reset_payload: got pc=%0h type=%0h fmt=%0b imm=%0h ill=%0b expected all 0",
                               out_pc, out_type, out_format, out_imm, out_illegal);
        end
    endtask

    task automatic test_first_fetch();
        out_ready = 1'b1;
        rst_n     = 1'b1;
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b1 || out_pc !== 30'd0) begin
            errors++; $display("[TB] FAIL first_head: got valid=%0b pc=%0h expected valid=1 pc=0", out_valid, out_pc);
        end
        checks++;
        if (out_type !== 23'h010000 || out_format !== 5'b01000 || out_imm !== 32'd5) begin
            errors++; $display("[TB] FAIL first_addi: got type=%0h fmt=%0b imm=%0h expected type=10000 fmt=01000 imm=5",
                               out_type, out_format, out_imm);
        end
        @(negedge clk);
        checks++;
        if (mem_addr_I !== 30'd2) begin
            errors++; $display("[TB] FAIL first_addr: got %0h expected 2", mem_addr_I);
        end
        checks++;
        if (out_pc !== 30'd1 || out_type !== 23'h000080 || out_format !== 5'b10000 || out_imm !== 32'd0) begin
            errors++; $display("[TB] FAIL sub_decode: got pc=%0h type=%0h fmt=%0b imm=%0h expected pc=1 type=80 fmt=10000 imm=0",
                               out_pc, out_type, out_format, out_imm);
        end
        @(negedge clk);
        checks++;
        if (out_pc !== 30'd2 || out_type !== 23'h100000 || out_format !== 5'b00010 || out_imm !== 32'hFFFF_FFFC) begin
            errors++; $display("[TB] FAIL beq_decode: got pc=%0h type=%0h fmt=%0b imm=%0h expected pc=2 type=100000 fmt=00010 imm=fffffffc",
                               out_pc, out_type, out_format, out_imm);
        end
    endtask

    task automatic test_back_to_back();
        for (int k = 3; k < 7; k++) begin
            @(negedge clk);
            checks++;
            if (out_valid !== 1'b1 || out_pc !== 30'(k) || out_imm !== 32'(k) || fifo_count !== 3'd1) begin
                errors++; $display("[TB] FAIL stream_%0d: got valid=%0b pc=%0h imm=%0h count=%0d expected valid=1 pc=%0h imm=%0h count=1",
                                   k, out_valid, out_pc, out_imm, fifo_count, k, k);
            end
        end
    endtask

    task automatic test_backpressure();
        int exp_n;
        redirect_valid = 1'b1;
        redirect_addr  = 30'd0;
        out_ready      = 1'b0;
        @(negedge clk);
        redirect_valid = 1'b0;
        checks++;
        if (fifo_count !== 3'd0 || mem_addr_I !== 30'd0) begin
            errors++; $display("[TB] FAIL bp_start: got count=%0d addr=%0h expected count=0 addr=0", fifo_count, mem_addr_I);
        end
        for (int k = 1; k <= 8; k++) begin
            @(negedge clk);
            exp_n = (k < 4) ? k : 4;
            checks++;
            if (fifo_count !== 3'(exp_n) || mem_addr_I !== 30'(exp_n)) begin
                errors++; $display("[TB] FAIL bp_fill_%0d: got count=%0d addr=%0h expected count=%0d addr=%0h",
                                   k, fifo_count, mem_addr_I, exp_n, exp_n);
            end
        end
        checks++;
        if (out_pc !== 30'd0) begin
            errors++; $display("[TB] FAIL bp_head: got %0h expected 0", out_pc);
        end
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        checks++;
        if (fifo_count !== 3'd4 || mem_addr_I !== 30'd5 || out_pc !== 30'd1) begin
            errors++; $display("[TB] FAIL full_pushpop: got count=%0d addr=%0h pc=%0h expected count=4 addr=5 pc=1",
                               fifo_count, mem_addr_I, out_pc);
        end
        out_ready = 1'b1;
        for (int k = 1; k < 7; k++) begin
            checks++;
            if (out_valid !== 1'b1 || out_pc !== 30'(k)) begin
                errors++; $display("[TB] FAIL drain_%0d: got valid=%0b pc=%0h expected valid=1 pc=%0h", k, out_valid, out_pc, k);
            end
            @(negedge clk);
        end
    endtask

    task automatic test_redirect();
        logic [22:0] exp_type [8];
        logic [4:0]  exp_fmt  [8];
        logic [31:0] exp_imm  [8];
        logic        exp_ill  [8];
        logic        strict_mode;
`ifdef RV_DECODE_STRICT_EN
        strict_mode = 1'b1;
`else
        strict_mode = 1'b0;
`endif
        exp_type = '{23'h040000, 23'h020000, 23'h400000, 23'h000200,
                     23'h200000, 23'h000000, 23'h080000, 23'h000001};
        exp_fmt  = '{5'b01000, 5'b00100, 5'b00001, 5'b01000,
                     5'b01000, 5'b00000, 5'b00010, 5'b10000};
        exp_imm  = '{32'hFFFF_FFF8, 32'h0000_000C, 32'hFFFF_FFF8, 32'h0000_0403,
                     32'h0000_0004, 32'h0000_0000, 32'h0000_0010, 32'h0000_0000};
        exp_ill  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, strict_mode, 1'b0, 1'b0};

        redirect_valid = 1'b1;
        redirect_addr  = 30'd0;
        out_ready      = 1'b0;
        @(negedge clk);
        redirect_valid = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if (fifo_count !== 3'd3) begin
            errors++; $display("[TB] FAIL redir_pre_count: got %0d expected 3", fifo_count);
        end
        redirect_valid = 1'b1;
        redirect_addr  = 30'h40;
        out_ready      = 1'b1;
        @(negedge clk);
        redirect_valid = 1'b0;
        checks++;
        if (fifo_count !== 3'd0 || out_valid !== 1'b0 || mem_addr_I !== 30'h40) begin
            errors++; $display("[TB] FAIL redir_flush: got count=%0d valid=%0b addr=%0h expected count=0 valid=0 addr=40",
                               fifo_count, out_valid, mem_addr_I);
        end
        checks++;
        if (out_pc !== 30'd0 || out_type !== 23'd0 || out_imm !== 32'd0) begin
            errors++; $display("[TB] FAIL redir_payload: got pc=%0h type=%0h imm=%0h expected all 0", out_pc, out_type, out_imm);
        end
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            checks++;
            if (out_valid !== 1'b1 || out_pc !== 30'(32'h40 + i)) begin
                errors++; $display("[TB] FAIL redir_pc_%0d: got valid=%0b pc=%0h expected valid=1 pc=%0h",
                                   i, out_valid, out_pc, 32'h40 + i);
            end
            checks++;
            if (out_type !== exp_type[i] || out_format !== exp_fmt[i] ||
                out_imm !== exp_imm[i] || out_illegal !== exp_ill[i]) begin
                errors++; $display("[TB] FAIL decode_%0d: got type=%0h fmt=%0b imm=%0h ill=%0b expected type=%0h fmt=%0b imm=%0h ill=%0b",
                                   i, out_type, out_format, out_imm, out_illegal,
                                   exp_type[i], exp_fmt[i], exp_imm[i], exp_ill[i]);
            end
        end
    endtask

    task automatic test_reset_midstream();
        out_ready = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if (fifo_count !== 3'd3) begin
            errors++; $display("[TB] FAIL mid_pre_count: got %0d expected 3", fifo_count);
        end
        rst_n = 1'b0;
        #1;
        checks++;
        if (fifo_count !== 3'd0 || out_valid !== 1'b0 || mem_addr_I !== 30'd0 || out_pc !== 30'd0) begin
            errors++; $display("[TB] FAIL mid_reset: got count=%0d valid=%0b addr=%0h pc=%0h expected 0 0 0 0",
                               fifo_count, out_valid, mem_addr_I, out_pc);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if (fifo_count !== 3'd1 || out_pc !== 30'd0 || out_imm !== 32'd5) begin
            errors++; $display("[TB] FAIL mid_restart: got count=%0d pc=%0h imm=%0h expected count=1 pc=0 imm=5",
                               fifo_count, out_pc, out_imm);
        end
    endtask

    initial begin
        load_memory();
        $display("[TB] rv_fetch_decode directed bench starting");
        test_reset();
        test_first_fetch();
        test_back_to_back();
        test_backpressure();
        test_redirect();
        test_reset_midstream();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
